// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the fetched word into IF/ID,
// and handles stall, redirect-with-flush, HALT detection and a delivered-count.
module fetch_unit #(
    parameter int unsigned          ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [31:0]          HALT_WORD = 32'hFFFF_FFFF,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_addr,
    output logic [ADDR_W-1:0]   read_address,
    input  logic [31:0]         instruction,
    output logic [31:0]         if_instruction,
    output logic [ADDR_W-1:0]   if_pc,
    output logic                if_valid,
    output logic                halted,
    output logic [CNT_W-1:0]    fetch_count
);

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [ADDR_W-1:0]  pc_d;
    logic [INSTR_W-1:0] if_instruction_d;
    logic [ADDR_W-1:0]  if_pc_d;
    logic               if_valid_d;
    logic               halted_d;
    logic [CNT_W-1:0]   fetch_count_d;

    logic               is_halt_c;
    logic [CNT_W-1:0]   count_inc_c;

    // HALT detection on the word currently returned by instruction memory
    assign is_halt_c = (instruction == HALT_WORD);

    // Delivered-count increment, saturating at all-ones
    assign count_inc_c = (fetch_count == {CNT_W{1'b1}}) ? fetch_count
                                                        : fetch_count + CNT_W'(1);

    // Next-state and next-register values; every register holds unless a case moves it
    always_comb begin
        state_d          = state_q;
        pc_d             = read_address;
        if_instruction_d = if_instruction;
        if_pc_d          = if_pc;
        if_valid_d       = if_valid;
        halted_d         = halted;
        fetch_count_d    = fetch_count;

        case (state_q)
            ST_BOOT: begin
                // One idle cycle after reset: memory read not yet trusted, nothing captured
                if_valid_d = 1'b0;
                state_d    = ST_RUN;
            end

            ST_RUN: begin
                if (redirect_valid) begin
                    // Redirect wins over stall; flush IF/ID but keep its data registers
                    pc_d       = redirect_addr;
                    if_valid_d = 1'b0;
                end else if (stall) begin
                    // Decode is back-pressuring: everything holds
                    pc_d = read_address;
                end else begin
                    if_instruction_d = instruction;
                    if_pc_d          = read_address;
                    if_valid_d       = 1'b1;
                    fetch_count_d    = count_inc_c;
                    if (is_halt_c) begin
                        // HALT is still delivered downstream; PC parks on its address
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = read_address + ADDR_W'(1);
                    end
                end
            end

            ST_HALT: begin
                // Stall is irrelevant here; only a redirect restarts fetch
                if_valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d     = redirect_addr;
                    halted_d = 1'b0;
                    state_d  = ST_RUN;
                end
            end

            default: begin
                if_valid_d = 1'b0;
                state_d    = ST_BOOT;
            end
        endcase
    end

    // State and output registers with synchronous, highest-priority reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_BOOT;
            read_address   <= RESET_PC;
            if_instruction <= '0;
            if_pc          <= '0;
            if_valid       <= 1'b0;
            halted         <= 1'b0;
            fetch_count    <= '0;
        end else begin
            state_q        <= state_d;
            read_address   <= pc_d;
            if_instruction <= if_instruction_d;
            if_pc          <= if_pc_d;
            if_valid       <= if_valid_d;
            halted         <= halted_d;
            fetch_count    <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with hand-written corner sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic [7:0]  read_address;
    logic [31:0] instruction;
    logic [31:0] if_instruction;
    logic [7:0]  if_pc;
    logic        if_valid;
    logic        halted;
    logic [15:0] fetch_count;
    logic        x_inj;

    // Small-counter instance used only to reach saturation quickly
    logic        s_reset;
    logic [7:0]  s_rd;
    logic [31:0] s_instr;
    logic [31:0] s_if_instr;
    logic [7:0]  s_if_pc;
    logic        s_if_valid;
    logic        s_halted;
    logic [3:0]  s_count;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    function automatic logic [31:0] mv(input int i);
        return 32'hA5C0_0000 | 32'(i);
    endfunction

    assign instruction = x_inj ? 32'hxxxx_xxxx : mem[read_address];
    assign s_instr     = mv(int'(s_rd));

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .read_address   (read_address),
        .instruction    (instruction),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    fetch_unit #(.CNT_W(4)) u_sat (
        .clk            (clk),
        .reset          (s_reset),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_addr  (8'h00),
        .read_address   (s_rd),
        .instruction    (s_instr),
        .if_instruction (s_if_instr),
        .if_pc          (s_if_pc),
        .if_valid       (s_if_valid),
        .halted         (s_halted),
        .fetch_count    (s_count)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rv;
        logic [7:0]  ra;
        logic [7:0]  e_rd;
        logic [7:0]  e_pc;
        logic [31:0] e_ins;
        logic        e_v;
        logic        e_h;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic rst, input logic stl, input logic rv,
                                input logic [7:0] ra, input logic [7:0] e_rd,
                                input logic [7:0] e_pc, input logic [31:0] e_ins,
                                input logic e_v, input logic e_h, input logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rv = rv; v.ra = ra;
        v.e_rd = e_rd; v.e_pc = e_pc; v.e_ins = e_ins;
        v.e_v = e_v; v.e_h = e_h; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge
    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [7:0] ra, input logic x);
        @(negedge clk);
        reset = r; stall = s; redirect_valid = rv; redirect_addr = ra; x_inj = x;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_rd, input logic [7:0] e_pc,
                           input logic [31:0] e_ins, input logic e_v, input logic e_h,
                           input logic [15:0] e_cnt);
        chk({tag, ".read_address"},   32'(read_address),   32'(e_rd));
        chk({tag, ".if_pc"},          32'(if_pc),          32'(e_pc));
        chk({tag, ".if_instruction"}, if_instruction,      e_ins);
        chk({tag, ".if_valid"},       32'(if_valid),       32'(e_v));
        chk({tag, ".halted"},         32'(halted),         32'(e_h));
        chk({tag, ".fetch_count"},    32'(fetch_count),    32'(e_cnt));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
        x_inj = 1'b0; s_reset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = mv(i);
        mem[3] = HALTW;

        //                 rst stl rv  ra     rd     if_pc  ins        v  h  cnt
        vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 8'h00, 32'h0,     0, 0, 16'd0));  // reset
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 32'h0,     0, 0, 16'd0));  // BOOT
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h01, 8'h00, mv(0),     1, 0, 16'd1));  // A
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h02, 8'h01, mv(1),     1, 0, 16'd2));  // B
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h02, 8'h01, mv(1),     1, 0, 16'd2));  // stall x3
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h02, 8'h01, mv(1),     1, 0, 16'd2));
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h02, 8'h01, mv(1),     1, 0, 16'd2));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h03, 8'h02, mv(2),     1, 0, 16'd3));  // C
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h03, 8'h03, HALTW,     1, 1, 16'd4));  // HALT word
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h03, 8'h03, HALTW,     0, 1, 16'd4));  // halted
        vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 8'h03, HALTW,     0, 0, 16'd4));  // resume
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h01, 8'h00, mv(0),     1, 0, 16'd5));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h02, 8'h01, mv(1),     1, 0, 16'd6));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h03, 8'h02, mv(2),     1, 0, 16'd7));
        vecs.push_back(mk(0, 0, 1, 8'h05, 8'h05, 8'h02, mv(2),     0, 0, 16'd7));  // pc=5
        vecs.push_back(mk(0, 0, 1, 8'h40, 8'h40, 8'h02, mv(2),     0, 0, 16'd7));  // ->0x40
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h41, 8'h40, mv(8'h40), 1, 0, 16'd8));
        vecs.push_back(mk(0, 1, 1, 8'h80, 8'h80, 8'h40, mv(8'h40), 0, 0, 16'd8));  // redir+stall
        vecs.push_back(mk(0, 1, 0, 8'h00, 8'h80, 8'h40, mv(8'h40), 0, 0, 16'd8));
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h81, 8'h80, mv(8'h80), 1, 0, 16'd9));
        vecs.push_back(mk(0, 0, 1, 8'hFF, 8'hFF, 8'h80, mv(8'h80), 0, 0, 16'd9));  // ->0xFF
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'hFF, mv(8'hFF), 1, 0, 16'd10)); // wrap
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h01, 8'h00, mv(0),     1, 0, 16'd11));
        vecs.push_back(mk(1, 1, 1, 8'h77, 8'h00, 8'h00, 32'h0,     0, 0, 16'd0));  // reset mid-run
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h00, 8'h00, 32'h0,     0, 0, 16'd0));  // BOOT
        vecs.push_back(mk(0, 0, 0, 8'h00, 8'h01, 8'h00, mv(0),     1, 0, 16'd1));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].ra, 1'b0);
            chk_all($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_pc, vecs[i].e_ins,
                    vecs[i].e_v, vecs[i].e_h, vecs[i].e_cnt);
        end

        // X on instruction during stall, redirect, HALT and BOOT must not reach IF/ID
        step(0, 1, 0, 8'h00, 1'b1);
        chk_all("x_stall", 8'h01, 8'h00, mv(0), 1, 0, 16'd1);
        step(0, 0, 1, 8'h03, 1'b1);
        chk_all("x_redirect", 8'h03, 8'h00, mv(0), 0, 0, 16'd1);
        step(0, 0, 0, 8'h00, 1'b0);
        chk_all("halt_again", 8'h03, 8'h03, HALTW, 1, 1, 16'd2);
        step(0, 0, 0, 8'h00, 1'b1);
        chk_all("x_halt", 8'h03, 8'h03, HALTW, 0, 1, 16'd2);
        step(1, 0, 0, 8'h00, 1'b0);
        chk_all("reset_in_halt", 8'h00, 8'h00, 32'h0, 0, 0, 16'd0);
        step(0, 0, 0, 8'h00, 1'b1);
        chk_all("x_boot", 8'h00, 8'h00, 32'h0, 0, 0, 16'd0);
        step(0, 0, 0, 8'h00, 1'b0);
        chk_all("after_boot", 8'h01, 8'h00, mv(0), 1, 0, 16'd1);

        // Counter saturation on the 4-bit instance: BOOT + 19 deliveries
        @(negedge clk);
        s_reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("sat.fetch_count", 32'(s_count), 32'hF);
        chk("sat.read_address", 32'(s_rd), 32'd19);
        chk("sat.if_pc", 32'(s_if_pc), 32'd18);
        chk("sat.if_valid", 32'(s_if_valid), 32'd1);
        chk("sat.halted", 32'(s_halted), 32'd0);
        chk("sat.if_instruction", s_if_instr, mv(18));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
